// File: rtl/rs232_push_arbiter_pkg.sv
// Shared types and helpers for the packet-granular RS232 push arbiter.
package rs232_push_arbiter_pkg;

  localparam int unsigned ENTRY_W   = 9;
  localparam int unsigned MAX_PORTS = 8;
  localparam int unsigned IDX_W     = 3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of mask searching ptr, ptr+1, ... modulo num.
  function automatic rr_pick_t next_port(input logic [MAX_PORTS-1:0] mask,
                                         input logic [IDX_W-1:0]     ptr,
                                         input int unsigned          num);
    rr_pick_t         pick;
    int unsigned      p;
    logic [IDX_W-1:0] pi;
    pick = '0;
    for (int unsigned k = 0; k < MAX_PORTS; k++) begin
      p  = (32'(ptr) + k) % num;
      pi = IDX_W'(p);
      if (k < num && !pick.found && mask[pi]) begin
        pick.found = 1'b1;
        pick.idx   = pi;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rs232_push_arbiter_fifo.sv
// Per-port byte FIFO with registered fill count, almost-full and sticky overflow.
module push_fifo #(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AFULL_SLACK = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_c,
  output logic             empty_c,
  output logic             full_c,
  output logic             afull_o,
  output logic             overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             afull_q, overflow_q;
  logic             do_pop_c, do_push_c;

  assign empty_c   = (count_q == '0);
  assign full_c    = (count_q == CW'(DEPTH));
  assign head_c    = mem_q[rd_ptr_q];
  assign do_pop_c  = pop_i && !empty_c;
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign do_push_c = push_i && (!full_c || do_pop_c);
  assign count_d   = count_q + CW'(do_push_c) - CW'(do_pop_c);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      afull_q    <= (count_d >= CW'(DEPTH - AFULL_SLACK));
      overflow_q <= overflow_q | (push_i & full_c & ~do_pop_c);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push_c) mem_q[wr_ptr_q] <= data_i;
  end

  assign afull_o    = afull_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/rs232_push_arbiter.sv
// Round-robin, packet-atomic arbiter feeding one RS232 transmit push interface.
module rs232_push_arbiter
  import rs232_push_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned AFULL_SLACK = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [8*NUM_PORTS-1:0]       idata,
  input  logic [NUM_PORTS-1:0]         ilast,
  input  logic [NUM_PORTS-1:0]         ienable,
  output logic [NUM_PORTS-1:0]         iafull,
  output logic [NUM_PORTS-1:0]         ioverflow,
  output logic [7:0]                   odata,
  output logic                         olast,
  output logic [$clog2(NUM_PORTS)-1:0] ochannel,
  output logic                         oenable,
  input  logic                         oafull
);

  localparam int unsigned PTR_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] empty_c, full_c, pop_c;
  logic [ENTRY_W-1:0]   head_c [NUM_PORTS];
  logic [MAX_PORTS-1:0] avail_c;
  rr_pick_t             pick_c;

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   sel_c;
  logic               do_pop_c;
  logic [ENTRY_W-1:0] sel_head_c;

  logic [7:0]         odata_q;
  logic               olast_q, oenable_q;
  logic [PTR_W-1:0]   ochannel_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    push_fifo #(
      .WIDTH      (ENTRY_W),
      .DEPTH      (FIFO_DEPTH),
      .AFULL_SLACK(AFULL_SLACK)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push_i    (ienable[i]),
      .data_i    ({ilast[i], idata[8*i +: 8]}),
      .pop_i     (pop_c[i]),
      .head_c    (head_c[i]),
      .empty_c   (empty_c[i]),
      .full_c    (full_c[i]),
      .afull_o   (iafull[i]),
      .overflow_o(ioverflow[i])
    );
  end

  always_comb begin
    avail_c                = '0;
    avail_c[NUM_PORTS-1:0] = ~empty_c;
  end

  assign pick_c = next_port(avail_c, IDX_W'(rr_ptr_q), NUM_PORTS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  // Next-state: IDLE picks a port and pops its head; LOCKED drains only the granted port.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    sel_c      = grant_q;
    do_pop_c   = 1'b0;
    pop_c      = '0;
    case (state_q)
      ST_IDLE: begin
        if (!oafull && pick_c.found) begin
          sel_c    = PTR_W'(pick_c.idx);
          grant_d  = PTR_W'(pick_c.idx);
          do_pop_c = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!oafull && !empty_c[grant_q]) do_pop_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    sel_head_c = head_c[sel_c];
    if (do_pop_c) begin
      if (sel_head_c[ENTRY_W-1]) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (sel_c == PTR_W'(NUM_PORTS - 1)) ? '0 : sel_c + PTR_W'(1);
      end else begin
        state_d  = ST_LOCKED;
      end
    end
    pop_c[sel_c] = do_pop_c;
  end

  // One-cycle output stage: a pop in cycle t is presented in cycle t+1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      odata_q    <= '0;
      olast_q    <= 1'b0;
      ochannel_q <= '0;
      oenable_q  <= 1'b0;
    end else begin
      oenable_q <= do_pop_c;
      olast_q   <= do_pop_c & sel_head_c[ENTRY_W-1];
      if (do_pop_c) begin
        odata_q    <= sel_head_c[7:0];
        ochannel_q <= sel_c;
      end
    end
  end

  assign odata    = odata_q;
  assign olast    = olast_q;
  assign ochannel = ochannel_q;
  assign oenable  = oenable_q;

endmodule

// File: tb/tb_rs232_push_arbiter.sv
// Directed bench for rs232_push_arbiter: ordering, fairness, backpressure, overflow, reset.
module tb_rs232_push_arbiter;

  localparam int unsigned NP = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic [8*NP-1:0] idata;
  logic [NP-1:0]   ilast, ienable, iafull, ioverflow;
  logic [7:0]      odata;
  logic            olast;
  logic [1:0]      ochannel;
  logic            oenable;
  logic            oafull;

  int vectors;
  int miscompares;
  logic [10:0] outq [$];

  rs232_push_arbiter #(.NUM_PORTS(NP), .FIFO_DEPTH(8), .AFULL_SLACK(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .idata    (idata),
    .ilast    (ilast),
    .ienable  (ienable),
    .iafull   (iafull),
    .ioverflow(ioverflow),
    .odata    (odata),
    .olast    (olast),
    .ochannel (ochannel),
    .oenable  (oenable),
    .oafull   (oafull)
  );

  always #5 clock = ~clock;

  // Output log: {channel, last, data} for each emitted byte.
  always @(negedge clock) begin
    if (!reset && oenable) outq.push_back({ochannel, olast, odata});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ienable = '0;
    ilast   = '0;
    idata   = '0;
  endtask

  task automatic push(input int port, input logic [7:0] d, input logic l);
    ienable[port]       = 1'b1;
    ilast[port]         = l;
    idata[8*port +: 8]  = d;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_inputs();
    oafull = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    outq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    oafull = 1'b0;
    tick();
    tick();
    vectors += 6;
    if (odata !== 8'h00)     begin miscompares++; $display("FAIL reset_odata got %h want 00", odata); end
    if (olast !== 1'b0)      begin miscompares++; $display("FAIL reset_olast got %b want 0", olast); end
    if (ochannel !== 2'd0)   begin miscompares++; $display("FAIL reset_ochannel got %0d want 0", ochannel); end
    if (oenable !== 1'b0)    begin miscompares++; $display("FAIL reset_oenable got %b want 0", oenable); end
    if (iafull !== 4'h0)     begin miscompares++; $display("FAIL reset_iafull got %b want 0000", iafull); end
    if (ioverflow !== 4'h0)  begin miscompares++; $display("FAIL reset_ioverflow got %b want 0000", ioverflow); end
    reset = 1'b0;
    tick();
    outq.delete();
  endtask

  task automatic test_single_packet();
    logic       exp_en;
    logic [7:0] exp_d;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c < 3) push(0, 8'(8'h41 + c), c == 2);
      exp_en = (c >= 2 && c <= 4);
      exp_d  = 8'(8'h41 + c - 2);
      vectors++;
      if (oenable !== exp_en) begin
        miscompares++; $display("FAIL single_oenable cycle %0d got %b want %b", c, oenable, exp_en);
      end
      if (exp_en) begin
        vectors++;
        if ({ochannel, olast, odata} !== {2'd0, c == 4, exp_d}) begin
          miscompares++;
          $display("FAIL single_byte cycle %0d got ch%0d last%b %h want ch0 last%b %h",
                   c, ochannel, olast, odata, c == 4, exp_d);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_fairness();
    logic [10:0] exp [$];
    apply_reset();
    oafull = 1'b1;
    push(0, 8'hA0, 1'b0); push(1, 8'hB0, 1'b0); push(2, 8'hC0, 1'b0);
    tick();
    push(0, 8'hA1, 1'b1); push(1, 8'hB1, 1'b1); push(2, 8'hC1, 1'b1);
    tick();
    idle_inputs();
    tick();
    oafull = 1'b0;
    repeat (12) tick();
    exp = '{{2'd0, 1'b0, 8'hA0}, {2'd0, 1'b1, 8'hA1}, {2'd1, 1'b0, 8'hB0},
            {2'd1, 1'b1, 8'hB1}, {2'd2, 1'b0, 8'hC0}, {2'd2, 1'b1, 8'hC1}};
    vectors++;
    if (outq.size() != exp.size()) begin
      miscompares++; $display("FAIL fair_count got %0d want %0d", outq.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < outq.size(); k++) begin
      vectors++;
      if (outq[k] !== exp[k]) begin
        miscompares++; $display("FAIL fair_order idx %0d got %h want %h", k, outq[k], exp[k]);
      end
    end
    // rr pointer now 3; port 3 is empty so port 0 wins next.
    outq.delete();
    push(0, 8'hD0, 1'b0);
    tick();
    idle_inputs();
    push(0, 8'hD1, 1'b1);
    tick();
    idle_inputs();
    repeat (6) tick();
    exp = '{{2'd0, 1'b0, 8'hD0}, {2'd0, 1'b1, 8'hD1}};
    vectors++;
    if (outq.size() != exp.size()) begin
      miscompares++; $display("FAIL fair_wrap_count got %0d want %0d", outq.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < outq.size(); k++) begin
      vectors++;
      if (outq[k] !== exp[k]) begin
        miscompares++; $display("FAIL fair_wrap idx %0d got %h want %h", k, outq[k], exp[k]);
      end
    end
  endtask

  task automatic test_no_interleave();
    logic [10:0] exp [$];
    apply_reset();
    push(1, 8'h10, 1'b0); push(2, 8'h20, 1'b0);
    tick();
    idle_inputs();
    push(2, 8'h21, 1'b1);
    tick();
    idle_inputs();
    repeat (5) tick();
    push(1, 8'h11, 1'b1);
    tick();
    idle_inputs();
    repeat (8) tick();
    exp = '{{2'd1, 1'b0, 8'h10}, {2'd1, 1'b1, 8'h11},
            {2'd2, 1'b0, 8'h20}, {2'd2, 1'b1, 8'h21}};
    vectors++;
    if (outq.size() != exp.size()) begin
      miscompares++; $display("FAIL nointerleave_count got %0d want %0d", outq.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < outq.size(); k++) begin
      vectors++;
      if (outq[k] !== exp[k]) begin
        miscompares++; $display("FAIL nointerleave idx %0d got %h want %h", k, outq[k], exp[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [10:0] exp [$];
    int          held;
    apply_reset();
    held = 0;
    for (int c = 0; c < 14; c++) begin
      idle_inputs();
      if (c < 6) push(0, 8'(8'h60 + c), c == 5);
      oafull = (c >= 4);
      if (c >= 4 && oenable === 1'b1) held++;
      tick();
    end
    idle_inputs();
    oafull = 1'b0;
    vectors++;
    if (held != 1) begin
      miscompares++; $display("FAIL backpressure_inflight got %0d want 1", held);
    end
    repeat (10) tick();
    for (int k = 0; k < 6; k++) exp.push_back({2'd0, k == 5, 8'(8'h60 + k)});
    vectors++;
    if (outq.size() != exp.size()) begin
      miscompares++; $display("FAIL backpressure_count got %0d want %0d", outq.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < outq.size(); k++) begin
      vectors++;
      if (outq[k] !== exp[k]) begin
        miscompares++; $display("FAIL backpressure idx %0d got %h want %h", k, outq[k], exp[k]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [10:0] exp [$];
    apply_reset();
    oafull = 1'b1;
    for (int c = 0; c < 9; c++) begin
      vectors += 2;
      if (iafull[3] !== (c >= 5)) begin
        miscompares++; $display("FAIL ovf_iafull fill %0d got %b want %b", c, iafull[3], c >= 5);
      end
      if (ioverflow[3] !== 1'b0) begin
        miscompares++; $display("FAIL ovf_early fill %0d got %b want 0", c, ioverflow[3]);
      end
      idle_inputs();
      push(3, 8'(8'h80 + c), c == 7);
      tick();
    end
    idle_inputs();
    vectors += 2;
    if (ioverflow !== 4'b1000) begin
      miscompares++; $display("FAIL ovf_sticky got %b want 1000", ioverflow);
    end
    if (iafull !== 4'b1000) begin
      miscompares++; $display("FAIL ovf_iafull_full got %b want 1000", iafull);
    end
    oafull = 1'b0;
    repeat (14) tick();
    for (int k = 0; k < 8; k++) exp.push_back({2'd3, k == 7, 8'(8'h80 + k)});
    vectors += 3;
    if (outq.size() != exp.size()) begin
      miscompares++; $display("FAIL ovf_count got %0d want %0d", outq.size(), exp.size());
    end
    if (iafull !== 4'b0000) begin
      miscompares++; $display("FAIL ovf_drained_iafull got %b want 0000", iafull);
    end
    if (ioverflow !== 4'b1000) begin
      miscompares++; $display("FAIL ovf_still_sticky got %b want 1000", ioverflow);
    end
    for (int k = 0; k < exp.size() && k < outq.size(); k++) begin
      vectors++;
      if (outq[k] !== exp[k]) begin
        miscompares++; $display("FAIL ovf_data idx %0d got %h want %h", k, outq[k], exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [10:0] exp [$];
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      push(1, 8'(8'h90 + c), 1'b0);
      tick();
    end
    idle_inputs();
    push(1, 8'h93, 1'b1);
    // Cycle 3: second byte is on the output; reset after it is logged.
    @(negedge clock);
    #1;
    idle_inputs();
    reset = 1'b1;
    #1;
    vectors += 5;
    if (oenable !== 1'b0)   begin miscompares++; $display("FAIL midrst_oenable got %b want 0", oenable); end
    if (odata !== 8'h00)    begin miscompares++; $display("FAIL midrst_odata got %h want 00", odata); end
    if (olast !== 1'b0)     begin miscompares++; $display("FAIL midrst_olast got %b want 0", olast); end
    if (ochannel !== 2'd0)  begin miscompares++; $display("FAIL midrst_ochannel got %0d want 0", ochannel); end
    if (iafull !== 4'h0)    begin miscompares++; $display("FAIL midrst_iafull got %b want 0000", iafull); end
    tick();
    reset = 1'b0;
    tick();
    push(0, 8'hE0, 1'b0);
    tick();
    idle_inputs();
    push(0, 8'hE1, 1'b1);
    tick();
    idle_inputs();
    repeat (10) tick();
    exp = '{{2'd1, 1'b0, 8'h90}, {2'd1, 1'b0, 8'h91},
            {2'd0, 1'b0, 8'hE0}, {2'd0, 1'b1, 8'hE1}};
    vectors++;
    if (outq.size() != exp.size()) begin
      miscompares++; $display("FAIL midrst_count got %0d want %0d", outq.size(), exp.size());
    end
    for (int k = 0; k < exp.size() && k < outq.size(); k++) begin
      vectors++;
      if (outq[k] !== exp[k]) begin
        miscompares++; $display("FAIL midrst_seq idx %0d got %h want %h", k, outq[k], exp[k]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    oafull      = 1'b0;
    idle_inputs();
    test_reset();
    test_single_packet();
    test_fairness();
    test_no_interleave();
    test_backpressure();
    test_overflow();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rs232_push_arbiter.md
Name: rs232_push_arbiter

Overview:
- Shares one push-based byte sink among NUM_PORTS push-based byte sources, at packet granularity. The sink is the RS232 transmit path.
- Each source pushes bytes with an end-of-packet flag into a small per-port FIFO and is throttled by its own almost-full signal.
- Packets are granted round-robin and are never interleaved on the output.
- Sits between the command and telemetry producers and the single serial transmitter.

Parameters:
- NUM_PORTS, 4, number of requesters; 2..8.
- FIFO_DEPTH, 8, entries per port FIFO; power of two, >= 4.
- AFULL_SLACK, 3, iafull[i] is asserted when fill count >= FIFO_DEPTH - AFULL_SLACK.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  reset; one clock, reset is asynchronous and active-high.
- idata  in  8*NUM_PORTS  port i byte in bits [8i+7:8i].
- ilast  in  NUM_PORTS  port i byte is the last byte of its packet.
- ienable  in  NUM_PORTS  port i push strobe; one byte per cycle.
- iafull  out  NUM_PORTS  port i almost-full, registered.
- ioverflow  out  NUM_PORTS  sticky: a push to port i arrived while its FIFO was full.
- odata  out  8  output byte, registered.
- olast  out  1  output byte ends its packet.
- ochannel  out  clog2(NUM_PORTS)  source port of the output byte.
- oenable  out  1  output push strobe.
- oafull  in  1  sink almost-full; no pop is started while it is high.

Behaviour:
- Reset values: odata = 0, olast = 0, ochannel = 0, oenable = 0, iafull = 0, ioverflow = 0. All FIFOs empty, state IDLE, rr_ptr = 0, grant = 0.
- Reset asserted mid-packet discards all buffered data immediately. No partial packet is completed after reset.

Per-port FIFO:
- 9-bit entries {ilast, idata}, registered fill count.
- Write when ienable[i] and the FIFO is not full.
- Write while full: the byte is dropped and ioverflow[i] is set. ioverflow is cleared only by reset.
- Simultaneous push and pop on a full FIFO: the pop frees a slot, so the write is accepted and no overflow is flagged.
- Pointers wrap modulo FIFO_DEPTH.
- iafull[i] reflects the registered fill count; it may lag a push by one cycle.

Arbiter FSM (states IDLE, LOCKED):
- IDLE, with oafull = 0 and at least one non-empty FIFO:
  - Select the first non-empty port searching rr_ptr, rr_ptr+1, … modulo NUM_PORTS.
  - Set grant to that port and pop its head in the same cycle.
  - If the popped entry has last = 1: stay IDLE and set rr_ptr = grant + 1 (mod NUM_PORTS). Otherwise go to LOCKED.
- IDLE, with oafull = 1 or all FIFOs empty: no pop; stay IDLE.
- LOCKED: pop from FIFO[grant] only when it is non-empty and oafull = 0.
  - Popping an entry with last = 1 returns to IDLE and sets rr_ptr = grant + 1.
  - If FIFO[grant] is empty, wait indefinitely. Other ports are never served mid-packet.

Output and latency:
- A pop in cycle t produces oenable = 1 in cycle t+1, with the entry on odata/olast and grant on ochannel.
- Minimum latency: ienable in cycle t into an empty FIFO gives oenable in cycle t+2.
- Peak throughput: one byte per cycle.
- oafull is sampled in the pop cycle. After oafull rises, at most one more byte is pushed.
- A single-byte packet (ilast on its only byte) is valid and is handled entirely in IDLE.

Decomposition:
- Shared package:
  - localparam ENTRY_W = 9.
  - The state encoding constants ST_IDLE and ST_LOCKED.
  - A round-robin search function next_port(mask, ptr) returning the index and a found flag.
- One sub-module: push_fifo (parameters WIDTH, DEPTH, AFULL_SLACK), instantiated NUM_PORTS times through a generate loop.
- The arbiter FSM and the output register stage stay in the top module.

Test Plan:
- Single port, single packet: port 0 pushes 0x41, 0x42, 0x43 with ilast on 0x43 in cycles 0–2 → oenable cycles 2–4, odata 41, 42, 43, olast only on 43, ochannel = 0.
- Fairness:
  - Stimulus: ports 0, 1 and 2 each pre-load a 2-byte packet (0xA0/0xA1, 0xB0/0xB1, 0xC0/0xC1) with rr_ptr = 0.
  - Required output order: A0 A1 B0 B1 C0 C1.
  - Then port 0 pushes one more packet: the next grant goes to port 0 only after port 3 is found empty.
- No interleave:
  - Stimulus: port 1 sends 0x10, stalls 5 cycles, then sends 0x11 with ilast. Port 2 holds a full packet throughout.
  - Required response: output is 10 then 11, and no port-2 byte appears until after 11.
- Backpressure: hold oafull = 1 for 10 cycles mid-packet → no oenable while oafull = 1 beyond the one in-flight byte. The packet then resumes in order with no loss.
- Overflow:
  - Stimulus: oafull = 1; push 9 bytes into port 3 with FIFO_DEPTH = 8.
  - Required response: iafull[3] = 1 after fill reaches 5; ioverflow[3] = 1 after the 9th push; exactly 8 bytes emerge once oafull drops.
- Reset mid-packet: assert reset after 2 of 4 bytes have been output → all outputs are 0 at once. After release, the remaining bytes never appear and a new packet is served from port 0.
